mux_4to1: RTL and testbench
===========================

Name: mux_4to1

Overview:
- Four-input, one-output data selector with a 2-bit select.
- Provides a combinational output and a registered copy of the selected data and select.
- Used in the CPU datapath wherever one of four operand/result sources is steered onto a single bus.
- Registered outputs give downstream logic a clean, clocked version of the selection.

Parameters:
- WIDTH, 1, bit width of each data input and of the data outputs.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  data input, selected when sel = 2'b00.
- b  input  WIDTH  data input, selected when sel = 2'b01.
- c  input  WIDTH  data input, selected when sel = 2'b10.
- d  input  WIDTH  data input, selected when sel = 2'b11.
- sel  input  2  select code.
- out  output  WIDTH  combinational selected data.
- out_q  output  WIDTH  registered selected data.
- sel_q  output  2  registered select code.
- out_chg  output  1  registered one-cycle flag: the newly registered data differs from the previous out_q.

Behaviour:
- Combinational path, zero latency:
  - out = a when sel=00, b when sel=01, c when sel=10, d when sel=11.
  - All four codes are decoded; there is no default or illegal code.
  - out follows any change on a/b/c/d/sel in the same delta; no clock or reset involvement.
  - Simulation only: if sel contains X/Z, out is driven all-X. No synthesis impact.
- Registered path, 1-cycle latency:
  - On each rising clk edge: out_q <= out; sel_q <= sel; out_chg <= (out != out_q).
  - out_chg compares against the pre-edge out_q, so it is high for exactly the cycle after a differing value is captured.
  - A held value gives out_chg = 0 from the following cycle onward.
- Reset:
  - rst high immediately and asynchronously forces out_q = 0, sel_q = 2'b00, out_chg = 0, independent of clk.
  - These values are held while rst is high.
  - The combinational out stays live during reset.
  - First edge after rst deasserts: out_q captures out; out_chg = 1 if out != 0.
  - Reset mid-operation discards the registered state; there is no recovery of pre-reset values.
- Simultaneous change of data and sel in one cycle: the register captures the out value present at the edge. No glitch filtering is required on the combinational path.
- Width rule: all data paths are exactly WIDTH bits. No extension or truncation.

Decomposition:
- Shared package mux_pkg:
  - typedef enum logic [1:0] sel_t, values SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - The RTL decode uses these names.
- Optional sub-module mux_4to1_comb: the pure combinational selector, instantiated by mux_4to1, which adds the register stage.
- Keeping everything in a single module is also acceptable.

Test Plan:
- WIDTH=1, rst released; a=0,b=1,c=0,d=1; sel 00,01,10,11 held 10 time units each -> out = 0,1,0,1 within the same time step of each sel change.
- Same WIDTH; a=1,b=0,c=1,d=0; sel 00,01,10,11 -> out = 1,0,1,0. Change data with sel fixed at 10 -> out tracks c immediately.
- Registered path: clk running, pattern a=0,b=1,c=0,d=1; step sel once per cycle -> out_q and sel_q lag out and sel by one cycle; out_chg pulses 1 on every cycle where out_q toggles.
- Reset: out_q=1, sel_q=11; assert rst between clk edges -> out_q=0, sel_q=00, out_chg=0 immediately, while out still equals the selected input. Deassert with out=1 -> next edge gives out_q=1 and out_chg=1.
- WIDTH=8: a=8'h11, b=8'h22, c=8'h33, d=8'h44; sweep sel -> out = 11,22,33,44. Hold sel=11 for 3 cycles -> out_chg = 1 then 0, 0.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared select-code definitions for the 4:1 data selector
package mux_pkg;

  // Select codes steering one of four sources onto the output bus
  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_D = 2'b11
  } sel_t;

endpackage : mux_pkg

// File: rtl/mux_4to1_comb.sv
// rtl/mux_4to1_comb.sv - pure combinational 4:1 selector
module mux_4to1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  // Decode all four codes; the default arm is only reachable when sel carries
  // X/Z in simulation, where it propagates X instead of hiding the problem.
  always_comb begin
    out = '0;
    case (sel_t'(sel))
      SEL_A:   out = a;
      SEL_B:   out = b;
      SEL_C:   out = c;
      SEL_D:   out = d;
      default: out = 'x;
    endcase
  end

endmodule : mux_4to1_comb

// File: rtl/mux_4to1.sv
// rtl/mux_4to1.sv - 4:1 selector with registered data, select and change flag
module mux_4to1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic             out_chg
);

  mux_4to1_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .sel(sel),
    .out(out)
  );

  // Capture the selection; out_chg compares against the value held before this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      sel_q   <= SEL_A;
      out_chg <= 1'b0;
    end else begin
      out_q   <= out;
      sel_q   <= sel;
      out_chg <= (out != out_q);
    end
  end

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// tb/tb_mux_4to1.sv - directed table-driven bench for mux_4to1 at WIDTH 1 and 8
module tb_mux_4to1;

  logic       clk;
  logic       rst;
  logic       a1, b1, c1, d1;
  logic [1:0] sel1;
  logic       out1, out_q1, out_chg1;
  logic [1:0] sel_q1;
  logic [7:0] a8, b8, c8, d8;
  logic [1:0] sel8;
  logic [7:0] out8, out_q8;
  logic [1:0] sel_q8;
  logic       out_chg8;

  int n_cmp = 0;
  int n_bad = 0;

  mux_4to1 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel1),
    .out(out1), .out_q(out_q1), .sel_q(sel_q1), .out_chg(out_chg1)
  );

  mux_4to1 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8), .sel(sel8),
    .out(out8), .out_q(out_q8), .sel_q(sel_q8), .out_chg(out_chg8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       a, b, c, d;
    logic [1:0] sel;
    logic       exp;
  } comb1_t;

  typedef struct {
    logic [7:0] a, b, c, d;
    logic [1:0] sel;
    logic [7:0] exp;
  } comb8_t;

  typedef struct {
    logic [1:0] sel;
    logic       exp_q;
    logic       exp_chg;
  } seq_t;

  comb1_t v1[11];
  comb8_t v8[6];
  seq_t   vs[7];

  initial begin
    v1[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
    v1[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1};
    v1[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0};
    v1[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1};
    v1[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1};
    v1[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0};
    v1[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1};
    v1[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
    v1[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
    v1[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1};
    v1[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0};

    v8[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 2'b00, 8'h11};
    v8[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 2'b01, 8'h22};
    v8[2] = '{8'h11, 8'h22, 8'h33, 8'h44, 2'b10, 8'h33};
    v8[3] = '{8'h11, 8'h22, 8'h33, 8'h44, 2'b11, 8'h44};
    v8[4] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 2'b11, 8'h00};
    v8[5] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 2'b10, 8'hFF};

    // pattern a=0,b=1,c=0,d=1, out_q starts at 0 after reset
    vs[0] = '{2'b00, 1'b0, 1'b0};
    vs[1] = '{2'b01, 1'b1, 1'b1};
    vs[2] = '{2'b10, 1'b0, 1'b1};
    vs[3] = '{2'b11, 1'b1, 1'b1};
    vs[4] = '{2'b11, 1'b1, 1'b0};
    vs[5] = '{2'b00, 1'b0, 1'b1};
    vs[6] = '{2'b01, 1'b1, 1'b1};

    rst = 1'b1;
    {a1, b1, c1, d1} = 4'b1111;
    sel1 = 2'b10;
    {a8, b8, c8, d8} = {8'h11, 8'h22, 8'h33, 8'h44};
    sel8 = 2'b01;
    #2;
    check("reset_out_q1", {7'b0, out_q1}, 8'h00);
    check("reset_sel_q1", {6'b0, sel_q1}, 8'h00);
    check("reset_chg1", {7'b0, out_chg1}, 8'h00);
    check("reset_out_q8", out_q8, 8'h00);
    check("reset_out_live8", out8, 8'h22);
    @(posedge clk);
    #1;
    check("reset_hold_out_q8", out_q8, 8'h00);
    check("reset_hold_sel_q8", {6'b0, sel_q8}, 8'h00);

    // combinational path, clock ignored
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      {a1, b1, c1, d1} = {v1[i].a, v1[i].b, v1[i].c, v1[i].d};
      sel1 = v1[i].sel;
      #1;
      check($sformatf("comb1[%0d]", i), {7'b0, out1}, {7'b0, v1[i].exp});
    end
    for (int i = 0; i < 6; i++) begin
      {a8, b8, c8, d8} = {v8[i].a, v8[i].b, v8[i].c, v8[i].d};
      sel8 = v8[i].sel;
      #1;
      check($sformatf("comb8[%0d]", i), out8, v8[i].exp);
    end

    // registered path from a fresh reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    {a1, b1, c1, d1} = 4'b0101;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sel1 = vs[i].sel;
      @(posedge clk);
      #1;
      check($sformatf("seq_out_q[%0d]", i), {7'b0, out_q1}, {7'b0, vs[i].exp_q});
      check($sformatf("seq_sel_q[%0d]", i), {6'b0, sel_q1}, {6'b0, vs[i].sel});
      check($sformatf("seq_chg[%0d]", i), {7'b0, out_chg1}, {7'b0, vs[i].exp_chg});
    end

    // asynchronous reset between edges with out_q=1, sel_q=11
    @(negedge clk);
    sel1 = 2'b11;
    @(posedge clk);
    #1;
    check("pre_rst_out_q", {7'b0, out_q1}, 8'h01);
    check("pre_rst_sel_q", {6'b0, sel_q1}, 8'h03);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_q", {7'b0, out_q1}, 8'h00);
    check("async_sel_q", {6'b0, sel_q1}, 8'h00);
    check("async_chg", {7'b0, out_chg1}, 8'h00);
    check("async_out_live", {7'b0, out1}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out_q", {7'b0, out_q1}, 8'h01);
    check("post_rst_chg", {7'b0, out_chg1}, 8'h01);
    check("post_rst_sel_q", {6'b0, sel_q1}, 8'h03);

    // WIDTH=8 hold: one cycle on 11, then sel=11 held three cycles
    @(negedge clk);
    {a8, b8, c8, d8} = {8'h11, 8'h22, 8'h33, 8'h44};
    sel8 = 2'b00;
    @(posedge clk);
    #1;
    check("hold8_pre_q", out_q8, 8'h11);
    @(negedge clk);
    sel8 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold8_q[%0d]", i), out_q8, 8'h44);
      check($sformatf("hold8_chg[%0d]", i), {7'b0, out_chg8}, (i == 0) ? 8'h01 : 8'h00);
    end

    // data and select change together: capture whatever out is at the edge
    @(negedge clk);
    sel8 = 2'b10;
    c8 = 8'h9C;
    @(posedge clk);
    #1;
    check("simul_q8", out_q8, 8'h9C);
    check("simul_sel_q8", {6'b0, sel_q8}, 8'h02);
    check("simul_chg8", {7'b0, out_chg8}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux_4to1
